rf_wport_arb: RTL and testbench

Write-port arbiter for the 32×32 general-purpose register file. It shares the file's single write port between the pipeline writeback stage and a multi-cycle long-latency unit (multiply/divide, 2-entry result buffer). Writeback has priority. The buffered long-latency results are protected from starvation by an age counter that stalls writeback. The block also reports whether a source register has a buffered write still pending, so the hazard unit can stall dependent instructions.

---
 rtl/rf_wport_arb.sv | 123 ++++++++++++
 tb/tb_rf_wport_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arb.sv
// Shares the register-file write port between writeback and a 2-entry long-latency result FIFO.
// Combinational grant; FIFO entries retire in order, and an age counter stalls writeback to prevent starvation.
module rf_wport_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wr,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_wr,
  input  logic [31:0] md_wd,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  output logic        stall_wb,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        rs_pending,
  output logic        rt_pending,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc
);

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  ent_t       ent0_q, ent1_q, ent0_d, ent1_d, md_ent;
  logic [1:0] count_q, count_d;
  logic [3:0] age_q, age_d;
  logic       wbreq, grant_head, grant_wb, push, keep0, keep1, head_gone;

  assign md_ent = '{wr: md_wr, wd: md_wd, pc: md_pc};
  assign wbreq  = wb_we && (wb_wr != 5'd0);

  assign md_ready   = !reset && (count_q < 2'd2);
  assign stall_wb   = !reset && (count_q != 2'd0) && (age_q == LIMIT);
  assign grant_head = !reset && (stall_wb || (!wbreq && count_q != 2'd0));
  assign grant_wb   = !reset && !stall_wb && wbreq;
  assign push       = md_valid && md_ready && (md_wr != 5'd0);

  assign rs_pending = !reset && (rs != 5'd0) &&
                      ((count_q != 2'd0 && ent0_q.wr == rs) || (count_q == 2'd2 && ent1_q.wr == rs));
  assign rt_pending = !reset && (rt != 5'd0) &&
                      ((count_q != 2'd0 && ent0_q.wr == rt) || (count_q == 2'd2 && ent1_q.wr == rt));

  always_comb begin
    rf_we = 1'b0;
    rf_wr = 5'd0;
    rf_wd = 32'd0;
    rf_pc = 32'd0;
    if (grant_head) begin
      rf_we = 1'b1;
      rf_wr = ent0_q.wr;
      rf_wd = ent0_q.wd;
      rf_pc = ent0_q.pc;
    end else if (grant_wb) begin
      rf_we = 1'b1;
      rf_wr = wb_wr;
      rf_wd = wb_wd;
      rf_pc = wb_pc;
    end
  end

  // Survivors after pop/squash are compacted to the front, then the new result goes to the tail.
  always_comb begin
    keep0   = (count_q != 2'd0) && !grant_head && !(grant_wb && ent0_q.wr == wb_wr);
    keep1   = (count_q == 2'd2) && !(grant_wb && ent1_q.wr == wb_wr);
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = 2'd0;
    case ({keep0, keep1})
      2'b11: count_d = 2'd2;
      2'b10: count_d = 2'd1;
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = 2'd1;
      end
      default: count_d = 2'd0;
    endcase
    if (push) begin
      if (count_d == 2'd0) begin
        ent0_d  = md_ent;
        count_d = 2'd1;
      end else begin
        ent1_d  = md_ent;
        count_d = 2'd2;
      end
    end
    head_gone = (count_q != 2'd0) && !keep0;
    if (count_q == 2'd0 || head_gone) begin
      age_d = 4'd0;
    end else if (age_q >= LIMIT) begin
      age_d = LIMIT;
    end else begin
      age_d = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      age_q   <= 4'd0;
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed and random stimulus for rf_wport_arb, checked each cycle against a queue-based reference model.
// Latency: outputs checked combinationally 1 time unit after each input change, model advanced at each posedge.
// Backpressure: md_valid is held until accepted; wb_* are held while stall_wb is asserted.
module tb_rf_wport_arb;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset, wb_we, md_valid, md_ready, stall_wb, rs_pending, rt_pending, rf_we;
    logic [4:0]  wb_wr, md_wr, rs, rt, rf_wr;
    logic [31:0] wb_wd, wb_pc, md_wd, md_pc, rf_wd, rf_pc;

    always #5 clk = ~clk;

    rf_wport_arb #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .wb_pc(wb_pc),
        .md_valid(md_valid), .md_wr(md_wr), .md_wd(md_wd), .md_pc(md_pc),
        .md_ready(md_ready), .stall_wb(stall_wb),
        .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_pc(rf_pc)
    );

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   age = 0;
    int   checks = 0;
    int   errors = 0;
    bit   last_stall = 0;
    int   md_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        if (r == 5'd0) return 0;
        foreach (q[i]) if (q[i].wr == r) return 1;
        return 0;
    endfunction

    // Check all outputs against the model, then advance the model across one edge.
    task automatic tick();
        logic        e_we, e_stall, e_rdy, e_rsp, e_rtp;
        logic [4:0]  e_wr;
        logic [31:0] e_wd, e_pc;
        bit          wbreq, head, wbg, hg;
        int          n;
        #1;
        n     = q.size();
        wbreq = wb_we && (wb_wr != 5'd0);
        e_wr = '0; e_wd = '0; e_pc = '0;
        if (reset) begin
            e_rdy = 0; e_stall = 0; e_rsp = 0; e_rtp = 0; head = 0; wbg = 0;
        end else begin
            e_rdy   = (n < 2);
            e_stall = (n > 0) && (age == LIM);
            head    = e_stall || (!wbreq && n > 0);
            wbg     = !head && wbreq;
            e_rsp   = hit(rs);
            e_rtp   = hit(rt);
            if (head) begin
                e_wr = q[0].wr; e_wd = q[0].wd; e_pc = q[0].pc;
            end else if (wbg) begin
                e_wr = wb_wr; e_wd = wb_wd; e_pc = wb_pc;
            end
        end
        e_we = head || wbg;
        chk("rf_we", rf_we, e_we);
        chk("md_ready", md_ready, e_rdy);
        chk("stall_wb", stall_wb, e_stall);
        chk("rs_pending", rs_pending, e_rsp);
        chk("rt_pending", rt_pending, e_rtp);
        if (e_we || reset) begin
            chk("rf_wr", rf_wr, e_wr);
            chk("rf_wd", rf_wd, e_wd);
            chk("rf_pc", rf_pc, e_pc);
        end
        if (head) md_log.push_back(int'(e_wr));
        last_stall = e_stall;
        @(posedge clk);
        if (reset) begin
            q.delete();
            age = 0;
        end else begin
            hg = 0;
            if (head) begin
                void'(q.pop_front());
                hg = 1;
            end else if (wbg) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].wr == wb_wr) begin
                        if (i == 0) hg = 1;
                        q.delete(i);
                    end
                end
            end
            if (md_valid && n < 2 && md_wr != 5'd0) q.push_back('{wr: md_wr, wd: md_wd, pc: md_pc});
            if (n == 0 || hg) age = 0;
            else if (age < LIM) age++;
        end
        #1;
    endtask

    initial begin
        int nstall, wb_before, stall_wr, pend, acc_cnt;
        logic [4:0] wrs [3];
        bit acc;

        // Reset with both requesters active
        reset = 1; wb_we = 1; wb_wr = 5'd3; wb_wd = 32'h11; wb_pc = 32'h100;
        md_valid = 1; md_wr = 5'd4; md_wd = 32'h44; md_pc = 32'h200; rs = 5'd4; rt = 5'd0;
        tick();
        tick();
        reset = 0; md_valid = 0; wb_we = 0;
        tick();
        chk("post_reset_pending", rs_pending, 1'b0);

        // Idle drain
        md_valid = 1; md_wr = 5'd5; md_wd = 32'hDEADBEEF; md_pc = 32'h300; rs = 5'd0;
        tick();
        md_valid = 0;
        #1;
        chk("drain_we", rf_we, 1'b1);
        chk("drain_wr", rf_wr, 5'd5);
        chk("drain_wd", rf_wd, 32'hDEADBEEF);
        tick();
        rs = 5'd5;
        tick();
        chk("drain_rs_pending", rs_pending, 1'b0);

        // Starvation: writeback busy on r3 while r7 waits
        md_log.delete();
        wb_we = 1; wb_wr = 5'd3; md_valid = 1; md_wr = 5'd7; md_wd = 32'h77;
        tick();
        md_valid = 0;
        nstall = 0; wb_before = 0; stall_wr = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stall_wb) begin
                nstall++;
                stall_wr = int'(rf_wr);
            end else if (nstall == 0) begin
                wb_before++;
            end
            tick();
        end
        chk("starve_wb_grants", wb_before, LIM);
        chk("starve_stalls", nstall, 1);
        chk("starve_stall_wr", stall_wr, 7);

        // Full buffer with a held third result
        md_log.delete();
        wrs[0] = 5'd8; wrs[1] = 5'd10; wrs[2] = 5'd12;
        acc_cnt = 0;
        md_valid = 1; md_wr = wrs[0]; md_wd = 32'h80;
        for (int i = 0; i < 30; i++) begin
            acc = (q.size() < 2) && md_valid;
            tick();
            if (acc) begin
                acc_cnt++;
                if (acc_cnt < 3) begin
                    md_wr = wrs[acc_cnt]; md_wd = 32'(acc_cnt) + 32'h80;
                end else begin
                    md_valid = 0;
                end
            end
        end
        chk("full_accepts", acc_cnt, 3);
        chk("full_order_n", md_log.size(), 3);
        if (md_log.size() == 3) begin
            chk("full_order0", md_log[0], 8);
            chk("full_order1", md_log[1], 10);
            chk("full_order2", md_log[2], 12);
        end

        // Squash: buffered r9 overwritten by younger writeback
        wb_we = 1; wb_wr = 5'd3; md_valid = 1; md_wr = 5'd9; md_wd = 32'd1; rt = 5'd9;
        tick();
        md_valid = 0; wb_wr = 5'd9; wb_wd = 32'd2;
        #1;
        chk("squash_rt_before", rt_pending, 1'b1);
        tick();
        chk("squash_rt_after", rt_pending, 1'b0);
        md_log.delete();
        wb_wr = 5'd3;
        for (int i = 0; i < 6; i++) tick();
        chk("squash_no_stale", md_log.size(), 0);

        // $0 handling
        md_valid = 1; md_wr = 5'd0; md_wd = 32'h5;
        tick();
        md_wr = 5'd11; md_wd = 32'hB;
        tick();
        md_valid = 0; wb_wr = 5'd0;
        #1;
        chk("zero_head_granted", rf_wr, 5'd11);
        tick();
        pend = int'(q.size());
        chk("zero_not_stored", pend, 0);

        // Randomized traffic with a reset pulse in the middle
        wb_we = 0;
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                wb_we = ($urandom_range(0, 9) < 7);
                wb_wr = 5'($urandom_range(0, 15));
                wb_wd = $urandom();
                wb_pc = $urandom();
            end
            if (!md_valid) begin
                md_valid = ($urandom_range(0, 2) == 0);
                md_wr = 5'($urandom_range(0, 15));
                md_wd = $urandom();
                md_pc = $urandom();
            end
            rs = 5'($urandom_range(0, 15));
            rt = 5'($urandom_range(0, 15));
            reset = (i == 300);
            acc = reset || (md_valid && q.size() < 2);
            tick();
            if (rf_we === 1'b1 && rf_wr === 5'd0) begin
                chk("rand_wr_nonzero", rf_wr == 5'd0, 1'b0);
            end
            if (acc) md_valid = 0;
        end
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
